// File: rtl/fxp_pkg.sv
// Shared Q4.4 constants, FSM state encoding and the signed saturation helper
// used across the fixed-point datapath.
package fxp_pkg;

   localparam int Q_INT  = 4;
   localparam int Q_FRAC = 4;
   localparam int Q_W    = Q_INT + Q_FRAC;

   typedef enum logic {
      ST_ACC  = 1'b0,
      ST_DONE = 1'b1
   } state_t;

   // Clamp a sign-extended value into the signed range of 'width' bits.
   function automatic logic signed [31:0] sat_clip(input logic signed [31:0] value,
                                                   input int               width);
      logic signed [31:0] hi_v;
      logic signed [31:0] lo_v;
      logic signed [31:0] res_v;
      hi_v = (32'sd1 <<< (width - 1)) - 32'sd1;
      lo_v = -(32'sd1 <<< (width - 1));
      if (value > hi_v) begin
         res_v = hi_v;
      end else if (value < lo_v) begin
         res_v = lo_v;
      end else begin
         res_v = value;
      end
      return res_v;
   endfunction

endpackage

// File: rtl/fxp_sat.sv
// Combinational signed clamp from IN_W to OUT_W bits with a flag that reports
// whether the value had to be clipped. IN_W must be below 32.
module fxp_sat
   import fxp_pkg::*;
#(
   parameter int IN_W  = 17,
   parameter int OUT_W = 16
) (
   input  logic signed [IN_W-1:0]  din,
   output logic signed [OUT_W-1:0] dout,
   output logic                    clipped
);

   logic signed [31:0] wide_s;
   logic signed [31:0] clip_s;

   // Widen, clamp through the shared helper, and flag any change of value.
   always_comb begin
      wide_s  = {{(32-IN_W){din[IN_W-1]}}, din};
      clip_s  = sat_clip(wide_s, OUT_W);
      dout    = clip_s[OUT_W-1:0];
      clipped = (clip_s != wide_s);
   end

endmodule

// File: rtl/fixedpoint_acc.sv
// Frame accumulator for rounded Q4.4 products: sums one frame into a saturating
// wide accumulator and hands out a clamped OUT_W result over valid/ready.
module fixedpoint_acc
   import fxp_pkg::*;
#(
   parameter  int IN_W    = Q_W,
   parameter  int ACC_W   = 16,
   parameter  int OUT_W   = Q_W,
   parameter  int MAX_LEN = 16,
   localparam int CNT_W   = $clog2(MAX_LEN + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    clr,
   input  logic                    in_valid,
   output logic                    in_ready,
   input  logic signed [IN_W-1:0]  in_data,
   input  logic                    in_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic signed [OUT_W-1:0] out_data,
   output logic [CNT_W-1:0]        out_cnt,
   output logic                    out_ovf,
   output logic                    out_len_err
);

   state_t                  state_r, state_nx;
   logic signed [ACC_W-1:0] acc_r, acc_nx, acc_sat_s;
   logic signed [ACC_W:0]   sum_s;
   logic [CNT_W-1:0]        cnt_r, cnt_nx, cnt_inc_s;
   logic                    sat_r, sat_nx;
   logic                    acc_clip_s, out_clip_s;
   logic                    in_ready_s, beat_s, close_s, len_hit_s;
   logic signed [OUT_W-1:0] out_sat_s;
   logic                    out_valid_r, out_valid_nx;
   logic signed [OUT_W-1:0] out_data_r, out_data_nx;
   logic [CNT_W-1:0]        out_cnt_r, out_cnt_nx;
   logic                    out_ovf_r, out_ovf_nx;
   logic                    out_len_err_r, out_len_err_nx;

   assign in_ready_s  = rst_n & (state_r == ST_ACC);
   assign in_ready    = in_ready_s;
   assign out_valid   = out_valid_r;
   assign out_data    = out_data_r;
   assign out_cnt     = out_cnt_r;
   assign out_ovf     = out_ovf_r;
   assign out_len_err = out_len_err_r;

   // One guard bit above the accumulator so the add itself can never wrap.
   always_comb begin
      sum_s     = {acc_r[ACC_W-1], acc_r} + {{(ACC_W+1-IN_W){in_data[IN_W-1]}}, in_data};
      cnt_inc_s = cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      len_hit_s = (cnt_inc_s == CNT_W'(MAX_LEN));
      beat_s    = in_valid & in_ready_s;
      close_s   = beat_s & (in_last | len_hit_s);
   end

   fxp_sat #(.IN_W(ACC_W + 1), .OUT_W(ACC_W)) u_acc_sat (
      .din     (sum_s),
      .dout    (acc_sat_s),
      .clipped (acc_clip_s)
   );

   fxp_sat #(.IN_W(ACC_W), .OUT_W(OUT_W)) u_out_sat (
      .din     (acc_sat_s),
      .dout    (out_sat_s),
      .clipped (out_clip_s)
   );

   // Next-state and next-result logic; clr outranks both handshakes.
   always_comb begin
      state_nx       = state_r;
      acc_nx         = acc_r;
      cnt_nx         = cnt_r;
      sat_nx         = sat_r;
      out_valid_nx   = out_valid_r;
      out_data_nx    = out_data_r;
      out_cnt_nx     = out_cnt_r;
      out_ovf_nx     = out_ovf_r;
      out_len_err_nx = out_len_err_r;
      if (clr) begin
         state_nx     = ST_ACC;
         acc_nx       = '0;
         cnt_nx       = '0;
         sat_nx       = 1'b0;
         out_valid_nx = 1'b0;
      end else begin
         case (state_r)
            ST_ACC: begin
               if (beat_s) begin
                  acc_nx = acc_sat_s;
                  cnt_nx = cnt_inc_s;
                  sat_nx = sat_r | acc_clip_s;
                  if (close_s) begin
                     state_nx       = ST_DONE;
                     out_valid_nx   = 1'b1;
                     out_data_nx    = out_sat_s;
                     out_cnt_nx     = cnt_inc_s;
                     out_ovf_nx     = sat_r | acc_clip_s | out_clip_s;
                     out_len_err_nx = ~in_last;
                  end else begin
                     state_nx = ST_ACC;
                  end
               end else begin
                  state_nx = ST_ACC;
               end
            end
            ST_DONE: begin
               if (out_ready) begin
                  state_nx     = ST_ACC;
                  acc_nx       = '0;
                  cnt_nx       = '0;
                  sat_nx       = 1'b0;
                  out_valid_nx = 1'b0;
               end else begin
                  state_nx = ST_DONE;
               end
            end
            default: begin
               state_nx     = ST_ACC;
               out_valid_nx = 1'b0;
            end
         endcase
      end
   end

   // State, accumulator and registered result outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r       <= ST_ACC;
         acc_r         <= '0;
         cnt_r         <= '0;
         sat_r         <= 1'b0;
         out_valid_r   <= 1'b0;
         out_data_r    <= '0;
         out_cnt_r     <= '0;
         out_ovf_r     <= 1'b0;
         out_len_err_r <= 1'b0;
      end else begin
         state_r       <= state_nx;
         acc_r         <= acc_nx;
         cnt_r         <= cnt_nx;
         sat_r         <= sat_nx;
         out_valid_r   <= out_valid_nx;
         out_data_r    <= out_data_nx;
         out_cnt_r     <= out_cnt_nx;
         out_ovf_r     <= out_ovf_nx;
         out_len_err_r <= out_len_err_nx;
      end
   end

endmodule

// File: tb/tb_fixedpoint_acc.sv
// Bench for fixedpoint_acc: default build plus an ACC_W=9 build on shared inputs,
// table vectors, hand-written corner sequences and randomized frames vs a model.
module tb_fixedpoint_acc;

   logic       clk = 1'b0;
   logic       rst_n, clr, in_valid, in_last, out_ready;
   logic [7:0] in_data;
   logic       in_ready, out_valid, out_ovf, out_len_err;
   logic [7:0] out_data;
   logic [4:0] out_cnt;
   logic       in_ready_9, out_valid_9, out_ovf_9, out_len_err_9;
   logic [7:0] out_data_9;
   logic [4:0] out_cnt_9;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   fixedpoint_acc dut (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
      .out_cnt(out_cnt), .out_ovf(out_ovf), .out_len_err(out_len_err)
   );

   fixedpoint_acc #(.ACC_W(9)) dut9 (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready_9), .in_data(in_data), .in_last(in_last),
      .out_valid(out_valid_9), .out_ready(out_ready), .out_data(out_data_9),
      .out_cnt(out_cnt_9), .out_ovf(out_ovf_9), .out_len_err(out_len_err_9)
   );

   typedef struct {
      logic [7:0] data;
      bit         last;
      bit         chk;
      logic [7:0] e_data;
      logic [4:0] e_cnt;
      bit         e_ovf;
      bit         e_len;
   } vec_t;

   vec_t tbl[$];

   function automatic void add(input logic [7:0] d, input bit l, input bit c,
                               input logic [7:0] ed, input logic [4:0] ec,
                               input bit eo, input bit el);
      vec_t v;
      v.data = d; v.last = l; v.chk = c;
      v.e_data = ed; v.e_cnt = ec; v.e_ovf = eo; v.e_len = el;
      tbl.push_back(v);
   endfunction

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Frame result from the rules: saturating add at accw bits, then clamp to 8 bits.
   function automatic void model(input int q[$], input bit hl, input int accw,
                                 output logic [7:0] od, output logic [4:0] oc,
                                 output bit ov, output bit le);
      int acc = 0;
      int o;
      bit s = 1'b0;
      int amax = (1 <<< (accw - 1)) - 1;
      int amin = -(1 <<< (accw - 1));
      foreach (q[i]) begin
         acc += q[i];
         if (acc > amax) begin acc = amax; s = 1'b1; end
         else if (acc < amin) begin acc = amin; s = 1'b1; end
      end
      o = acc;
      if (o > 127) begin o = 127; s = 1'b1; end
      else if (o < -128) begin o = -128; s = 1'b1; end
      od = o[7:0];
      oc = 5'(q.size());
      ov = s;
      le = !hl;
   endfunction

   task automatic send(input logic [7:0] d, input bit l);
      int waited = 0;
      @(negedge clk);
      in_valid = 1'b1; in_data = d; in_last = l;
      while (!in_ready && waited < 64) begin
         @(negedge clk);
         waited++;
      end
      check("send_ready", 32'(in_ready), 32'd1);
      check("send_ready_9", 32'(in_ready_9), 32'd1);
      if (in_ready) begin
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0; in_last = 1'b0;
   endtask

   // Called #1 after the closing edge: the result must already be valid.
   task automatic collect(input logic [7:0] ed, input logic [4:0] ec, input bit eo, input bit el,
                          input logic [7:0] ed9, input bit eo9, input int hold);
      check("latency_valid", 32'(out_valid), 32'd1);
      check("latency_valid_9", 32'(out_valid_9), 32'd1);
      check("out_data", 32'(out_data), 32'(ed));
      check("out_cnt", 32'(out_cnt), 32'(ec));
      check("out_ovf", 32'(out_ovf), 32'(eo));
      check("out_len_err", 32'(out_len_err), 32'(el));
      check("out_data_9", 32'(out_data_9), 32'(ed9));
      check("out_cnt_9", 32'(out_cnt_9), 32'(ec));
      check("out_ovf_9", 32'(out_ovf_9), 32'(eo9));
      check("out_len_err_9", 32'(out_len_err_9), 32'(el));
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         check("hold_valid", 32'(out_valid), 32'd1);
         check("hold_in_ready", 32'(in_ready), 32'd0);
         check("hold_data", 32'(out_data), 32'(ed));
         check("hold_cnt", 32'(out_cnt), 32'(ec));
      end
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check("post_hs_valid", 32'(out_valid), 32'd0);
      check("post_hs_data_kept", 32'(out_data), 32'(ed));
      check("post_hs_in_ready", 32'(in_ready), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [7:0] od, od9;
      logic [4:0] oc;
      bit         ov, ov9, le;
      int         q[$];
      int         len;
      bit         hl;
      logic [7:0] b;

      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b1; in_data = 8'h11; in_last = 1'b0; out_ready = 1'b0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", 32'(in_ready), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_data", 32'(out_data), 32'd0);
      check("rst_out_cnt", 32'(out_cnt), 32'd0);
      in_valid = 1'b0;
      rst_n = 1'b1;
      #1;
      check("rel_in_ready", 32'(in_ready), 32'd1);

      add(8'd5,   1'b0, 1'b0, 8'd0,  5'd0, 1'b0, 1'b0);
      add(8'hFD,  1'b0, 1'b0, 8'd0,  5'd0, 1'b0, 1'b0);
      add(8'd10,  1'b1, 1'b1, 8'd12, 5'd3, 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) add(8'd127, i == 3, i == 3, 8'd127, 5'd4, 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) add(8'h80,  i == 3, i == 3, 8'h80,  5'd4, 1'b1, 1'b0);
      for (int i = 0; i < 16; i++) add(8'd1, 1'b0,    i == 15, 8'd16, 5'd16, 1'b0, 1'b1);
      for (int i = 0; i < 16; i++) add(8'd1, i == 15, i == 15, 8'd16, 5'd16, 1'b0, 1'b0);
      foreach (tbl[i]) begin
         send(tbl[i].data, tbl[i].last);
         if (tbl[i].chk)
            collect(tbl[i].e_data, tbl[i].e_cnt, tbl[i].e_ovf, tbl[i].e_len,
                    tbl[i].e_data, tbl[i].e_ovf, 0);
      end

      // Backpressure with upstream already holding the next beat during DONE.
      send(8'd3, 1'b0);
      send(8'd4, 1'b1);
      @(negedge clk);
      in_valid = 1'b1; in_data = 8'd7; in_last = 1'b1;
      #1;
      collect(8'd7, 5'd2, 1'b0, 1'b0, 8'd7, 1'b0, 5);
      @(posedge clk);
      #1;
      in_valid = 1'b0; in_last = 1'b0;
      collect(8'd7, 5'd1, 1'b0, 1'b0, 8'd7, 1'b0, 0);

      // clr drops the partial frame and the beat offered alongside it.
      send(8'd50, 1'b0);
      send(8'd50, 1'b0);
      @(negedge clk);
      clr = 1'b1; in_valid = 1'b1; in_data = 8'd50;
      @(posedge clk);
      #1;
      clr = 1'b0; in_valid = 1'b0;
      check("clr_out_valid", 32'(out_valid), 32'd0);
      check("clr_in_ready", 32'(in_ready), 32'd1);
      send(8'd7, 1'b1);
      collect(8'd7, 5'd1, 1'b0, 1'b0, 8'd7, 1'b0, 0);

      // Narrow accumulator saturates at 255 and -256 where the wide one does not.
      for (int i = 0; i < 3; i++) send(8'd127, i == 2);
      collect(8'd127, 5'd3, 1'b1, 1'b0, 8'd127, 1'b1, 0);
      for (int i = 0; i < 3; i++) send(8'd127, 1'b0);
      send(8'h80, 1'b0);
      send(8'h80, 1'b1);
      collect(8'd125, 5'd5, 1'b0, 1'b0, 8'hFF, 1'b1, 0);

      for (int f = 0; f < 40; f++) begin
         q.delete();
         len = $urandom_range(1, 16);
         hl = (len < 16) ? 1'b1 : 1'($urandom_range(0, 1));
         for (int i = 0; i < len; i++) begin
            if ($urandom_range(0, 3) == 0) q.push_back(($urandom_range(0, 1) == 1) ? 127 : -128);
            else begin
               b = 8'($urandom);
               q.push_back(int'($signed(b)));
            end
         end
         model(q, hl, 16, od, oc, ov, le);
         model(q, hl, 9, od9, oc, ov9, le);
         for (int i = 0; i < len; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            b = q[i][7:0];
            send(b, hl && (i == len - 1));
         end
         collect(od, oc, ov, le, od9, ov9, $urandom_range(0, 3));
      end

      // Reset while a result is pending wipes it.
      send(8'd3, 1'b1);
      @(negedge clk);
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      check("rst2_out_valid", 32'(out_valid), 32'd0);
      check("rst2_out_data", 32'(out_data), 32'd0);
      check("rst2_out_cnt", 32'(out_cnt), 32'd0);
      check("rst2_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check("rst2_rel_in_ready", 32'(in_ready), 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
